uart_move_ctrl: RTL and testbench
=================================

# uart_move_ctrl

Command sequencer between `uart_rx` and the tic-tac-toe game FSM. It consumes the single-cycle byte strobes from `uart_rx` and parses short ASCII command frames. Valid frames become move or game-reset requests, delivered over a valid/ready handshake. Each frame is acknowledged by a one-byte reply through the `uart_tx` start/busy interface. Malformed input is rejected with an error code, and inter-byte stalls are timed out.

## Interface
- `TIMEOUT_CYCLES`, 86800: max clk cycles between bytes of one frame (10 byte times at 868 clk/bit); must be ≥ 2
- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  asynchronous, active-high; all state and outputs cleared on assertion
- `rx_data_valid`  in  1  one-cycle strobe from `uart_rx`; `rx_byte` valid in the same cycle
- `rx_byte`  in  8  received byte
- `move_valid`  out  1  move request pending
- `move_cell`  out  4  cell index 0–8, stable while `move_valid`=1
- `move_ready`  in  1  game FSM accepts move (handshake completes on edge with both high)
- `game_reset`  out  1  one-cycle pulse requesting a new game
- `tx_busy`  in  1  `uart_tx` busy
- `tx_start`  out  1  one-cycle pulse; `uart_tx` latches `tx_byte`
- `tx_byte`  out  8  reply byte: 0x4B 'K' = accepted, 0x45 'E' = rejected
- `err_pulse`  out  1  one-cycle error strobe
- `err_code`  out  2  0 = bad byte, 1 = timeout, 2 = overrun; holds last value
- `err_count`  out  8  saturating error count (stops at 255)

## Operation
- Frames (letters case-insensitive):
  - `M`/`m`, digit `1`–`9`, CR (0x0D) → move, `move_cell` = digit − 0x31
  - `R`/`r`, CR → game reset
- States: IDLE, GOT_M, GOT_DIGIT, GOT_R, ISSUE, ACK.
- IDLE:
  - 'M' → GOT_M; 'R' → GOT_R
  - CR and LF (0x0A) ignored silently
  - any other byte → bad-byte error
- GOT_M: digit 1–9 → GOT_DIGIT, digit latched; else bad-byte error.
- GOT_DIGIT: CR → ISSUE; else bad-byte error.
- GOT_R: CR → pulse `game_reset` on the transition cycle → ACK with 'K'; else bad-byte error.
- ISSUE:
  - `move_valid`=1
  - on `move_valid && move_ready` → ACK with 'K'
  - no timeout in this state
- ACK:
  - `tx_byte` set on entry
  - first cycle with `tx_busy`=0 → `tx_start`=1 → IDLE
- Bad byte or timeout in any GOT_* state (bad byte also in IDLE):
  - `err_pulse`, `err_code` updated, `err_count`++
  - → ACK with 'E'
- Timeout:
  - Inter-byte counter cleared on every `rx_data_valid` and on entering IDLE.
  - Fires in GOT_* states when the counter reaches `TIMEOUT_CYCLES`−1 with no strobe.
- Overrun: `rx_data_valid` in ISSUE or ACK → byte dropped; `err_pulse`, code 2, `err_count`++; state unaffected; no 'E' reply.
- Simultaneous events:
  - Strobe on the timeout cycle: byte is processed, no timeout.
  - Overrun in the same cycle as a handshake or `tx_start`: both take effect.
- Only one error is counted per cycle.

## Timing
- Reset values: state IDLE; `move_valid`, `move_cell`, `game_reset`, `tx_start`, `tx_byte`, `err_pulse`, `err_code`, `err_count` all 0; timer 0.
- Reset mid-frame or mid-handshake discards the pending move; no reply is sent.
- All outputs are registered.
- Byte to state change: 1 cycle. CR strobe at edge N → `move_valid`=1 after edge N+1.
- `move_valid` holds until the handshake edge; it deasserts and ACK is entered on that edge.
- `tx_start` asserts at the earliest one cycle after ACK entry. `tx_byte` is stable from ACK entry through the `tx_start` cycle.
- `game_reset` and `err_pulse` are exactly one cycle wide.
- Back-to-back frames: the next byte is accepted in IDLE on the cycle after `tx_start`.

## Test plan
- Send 'M','5',CR with `move_ready`=1 and `tx_busy`=0 → `move_valid` one cycle, `move_cell`=4, then `tx_start` with `tx_byte`=0x4B; `err_count`=0.
- Send 'm','9',CR with `move_ready` held low 50 cycles → `move_valid` stays high with `move_cell`=8 for 50 cycles. Strobe one byte during the stall → `err_code`=2, `err_count`=1, move still delivered, then 'K'.
- Send 'M','0',CR → bad-byte error on '0', reply 0x45, `err_code`=0. The following CR is ignored in IDLE; no `move_valid`.
- With `TIMEOUT_CYCLES`=1000, send 'M' then idle 1000 cycles → `err_pulse` with `err_code`=1, reply 'E', state IDLE.
- Send 'R',CR with `tx_busy` high for 20 cycles → `game_reset` one-cycle pulse. `tx_start` is held off until `tx_busy` falls, then `tx_byte`=0x4B.
- Assert `reset` while in ISSUE → all outputs 0 immediately. After release, 'M','1',CR yields `move_cell`=0.

Source files
------------

// File: rtl/uart_move_ctrl.sv
// uart_move_ctrl: parses ASCII move/reset frames from uart_rx and replies K/E through uart_tx
module uart_move_ctrl #(
  parameter int TIMEOUT_CYCLES = 86800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_byte,
  output logic       move_valid,
  output logic [3:0] move_cell,
  input  logic       move_ready,
  output logic       game_reset,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [7:0] err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, GOT_M, GOT_DIGIT, GOT_R, ISSUE, ACK} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] cell_n;
  logic [7:0] tx_byte_n;
  logic [1:0] code_n;
  logic tx_start_n, game_reset_n, err_n, bad, tmo, is_m, is_r, is_cr, is_digit, in_frame;
  // next-state, reply and error decode; registered outputs are computed one step ahead
  always_comb begin
    in_frame = state inside {GOT_M, GOT_DIGIT, GOT_R};
    tmo = in_frame && !rx_data_valid && timer == TW'(TIMEOUT_CYCLES - 1);
    is_m = (rx_byte | 8'h20) == 8'h6D;
    is_r = (rx_byte | 8'h20) == 8'h72;
    is_cr = rx_byte == 8'h0D;
    is_digit = rx_byte >= 8'h31 && rx_byte <= 8'h39;
    state_n = state;
    cell_n = move_cell;
    tx_byte_n = tx_byte;
    tx_start_n = 1'b0;
    game_reset_n = 1'b0;
    err_n = 1'b0;
    code_n = err_code;
    bad = 1'b0;
    case (state)
      IDLE:
        if (rx_data_valid) begin
          if (is_m) state_n = GOT_M;
          else if (is_r) state_n = GOT_R;
          else bad = !is_cr && rx_byte != 8'h0A;
        end
      GOT_M:
        if (rx_data_valid) begin
          if (is_digit) begin
            state_n = GOT_DIGIT;
            cell_n = rx_byte[3:0] - 4'd1;
          end else bad = 1'b1;
        end
      GOT_DIGIT:
        if (rx_data_valid) begin
          if (is_cr) state_n = ISSUE;
          else bad = 1'b1;
        end
      GOT_R:
        if (rx_data_valid) begin
          if (is_cr) begin
            state_n = ACK;
            tx_byte_n = 8'h4B;
            game_reset_n = 1'b1;
          end else bad = 1'b1;
        end
      ISSUE:
        if (move_valid && move_ready) begin
          state_n = ACK;
          tx_byte_n = 8'h4B;
        end
      ACK:
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    if (bad || tmo) begin
      state_n = ACK;
      tx_byte_n = 8'h45;
      err_n = 1'b1;
      code_n = tmo ? 2'd1 : 2'd0;
    end
    if (rx_data_valid && (state == ISSUE || state == ACK)) begin
      err_n = 1'b1;
      code_n = 2'd2;
    end
    timer_n = (rx_data_valid || !(state_n inside {GOT_M, GOT_DIGIT, GOT_R})) ? '0 : timer + TW'(1);
  end
  // state, timer and all outputs registered; reset drops any pending move silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      move_valid <= 1'b0;
      move_cell <= '0;
      game_reset <= 1'b0;
      tx_start <= 1'b0;
      tx_byte <= '0;
      err_pulse <= 1'b0;
      err_code <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      move_valid <= state_n == ISSUE;
      move_cell <= cell_n;
      game_reset <= game_reset_n;
      tx_start <= tx_start_n;
      tx_byte <= tx_byte_n;
      err_pulse <= err_n;
      err_code <= code_n;
      err_count <= err_count + {7'd0, err_n && err_count != 8'hFF};
    end
  end
endmodule

// File: tb/tb_uart_move_ctrl.sv
// tb_uart_move_ctrl: directed frames with hand-computed expectations for uart_move_ctrl
module tb_uart_move_ctrl;
  logic clk = 1'b0, reset = 1'b1, rx_data_valid = 1'b0, move_ready = 1'b0, tx_busy = 1'b0;
  logic [7:0] rx_byte = '0;
  logic move_valid, game_reset, tx_start, err_pulse;
  logic [3:0] move_cell;
  logic [7:0] tx_byte, err_count;
  logic [1:0] err_code;
  int n_cmp = 0, n_bad = 0;
  uart_move_ctrl #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid), .rx_byte(rx_byte),
    .move_valid(move_valid), .move_cell(move_cell), .move_ready(move_ready),
    .game_reset(game_reset), .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data_valid = 1'b1;
    rx_byte = b;
    tick();
    rx_data_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_move_valid", move_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_err_count", err_count, 0);
    check("rst_outs", {game_reset, tx_start, err_pulse, err_code, move_cell}, 0);
    reset = 1'b0;
    move_ready = 1'b1;
    send("M"); send("5"); send(8'h0D);
    check("m5_valid", move_valid, 1);
    check("m5_cell", move_cell, 4);
    tick();
    check("m5_valid_drop", move_valid, 0);
    check("m5_tx_byte", tx_byte, 8'h4B);
    check("m5_no_start_yet", tx_start, 0);
    tick();
    check("m5_tx_start", tx_start, 1);
    check("m5_err_count", err_count, 0);
    tick();
    check("m5_start_pulse", tx_start, 0);
    move_ready = 1'b0;
    send("m"); send("9"); send(8'h0D);
    check("m9_valid", move_valid, 1);
    check("m9_cell", move_cell, 8);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        rx_data_valid = 1'b1;
        rx_byte = 8'h41;
      end
      tick();
      rx_data_valid = 1'b0;
      if (i == 20) begin
        check("ovr_pulse", err_pulse, 1);
        check("ovr_code", err_code, 2);
        check("ovr_count", err_count, 1);
      end
      if (i == 21) check("ovr_pulse_width", err_pulse, 0);
      check("m9_stall_valid", move_valid, 1);
      check("m9_stall_cell", move_cell, 8);
    end
    move_ready = 1'b1;
    tick();
    check("m9_valid_drop", move_valid, 0);
    check("m9_tx_byte", tx_byte, 8'h4B);
    tick();
    check("m9_tx_start", tx_start, 1);
    send("M"); send("0");
    check("bad_pulse", err_pulse, 1);
    check("bad_code", err_code, 0);
    check("bad_count", err_count, 2);
    check("bad_tx_byte", tx_byte, 8'h45);
    tick();
    check("bad_tx_start", tx_start, 1);
    send(8'h0D);
    check("cr_idle_no_err", err_pulse, 0);
    check("cr_idle_count", err_count, 2);
    check("cr_idle_no_start", tx_start, 0);
    tick();
    check("cr_idle_no_move", move_valid, 0);
    send("M");
    for (int i = 0; i < 999; i++) tick();
    check("tmo_not_yet", err_pulse, 0);
    tick();
    check("tmo_pulse", err_pulse, 1);
    check("tmo_code", err_code, 1);
    check("tmo_count", err_count, 3);
    check("tmo_tx_byte", tx_byte, 8'h45);
    tick();
    check("tmo_tx_start", tx_start, 1);
    tx_busy = 1'b1;
    send("R"); send(8'h0D);
    check("r_game_reset", game_reset, 1);
    check("r_tx_byte", tx_byte, 8'h4B);
    tick();
    check("r_game_reset_width", game_reset, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      check("r_busy_hold", tx_start, 0);
    end
    tx_busy = 1'b0;
    tick();
    check("r_tx_start", tx_start, 1);
    check("r_tx_byte_hold", tx_byte, 8'h4B);
    tick();
    move_ready = 1'b0;
    send("M"); send("3"); send(8'h0D);
    check("pre_rst_valid", move_valid, 1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", move_valid, 0);
    check("async_rst_count", err_count, 0);
    check("async_rst_tx_byte", tx_byte, 0);
    check("async_rst_outs", {game_reset, tx_start, err_pulse, err_code, move_cell}, 0);
    tick();
    reset = 1'b0;
    move_ready = 1'b1;
    send("M"); send("1"); send(8'h0D);
    check("m1_valid", move_valid, 1);
    check("m1_cell", move_cell, 0);
    tick();
    check("m1_tx_byte", tx_byte, 8'h4B);
    tick();
    check("m1_tx_start", tx_start, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
